uart_serial_send: RTL and testbench
===================================

Name: uart_serial_send

Overview:
- Minimal UART transmitter. Serializes one byte per write into an 8N1 frame: 1 start bit (low), 8 data bits LSB first, 1 stop bit (high).
- Sits between a byte-producing host (CPU/FSM) and the TX pin. The host writes when BUSY is low.
- Bit period is a fixed integer number of clock cycles, set by a parameter.

Parameters:
- WAIT_DIV, 868, clock cycles per serial bit (100 MHz / 115200 baud); legal range ≥ 2.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST  input  1  asynchronous, active-high reset.
- DATA_IN  input  8  byte to transmit; sampled only on an accepted write.
- WE  input  1  write strobe; one-cycle pulse or level.
- DATA_OUT  output  1  serial TX line; idles high.
- BUSY  output  1  high while a frame is in progress.

Behaviour:
- Reset (async, RST=1): DATA_OUT=1, BUSY=0, state IDLE, bit counter=0, clock-divider counter=0, shift register=0.
- Write acceptance:
  - A write is accepted on a rising edge where WE=1 and BUSY=0.
  - DATA_IN is latched into the shift register on that edge.
  - On the same edge, BUSY and DATA_OUT update with one registered cycle of latency: BUSY=1 and DATA_OUT=0 (start bit) are visible from the next cycle.
- WE while BUSY=1: ignored. No queuing; the current frame and latched data are unaffected. DATA_IN changes after acceptance are ignored.
- State machine:
  - IDLE -> START on an accepted write.
  - START: DATA_OUT=0 for WAIT_DIV cycles.
  - DATA: 8 bits, LSB first, each held WAIT_DIV cycles; bit index 0..7.
  - STOP: DATA_OUT=1 for WAIT_DIV cycles.
  - Then IDLE with BUSY=0.
- Divider: counts 0..WAIT_DIV-1; the terminal count advances to the next bit/state. The divider restarts at 0 on acceptance.
- BUSY is high for exactly 10*WAIT_DIV cycles per frame. DATA_OUT is never glitch-low outside START and 0-data bits.
- Back-to-back: a WE on the first edge with BUSY=0 after STOP is accepted. The minimum frame-to-frame gap is 1 cycle of idle high.
- Reset mid-frame: aborts immediately. DATA_OUT returns high, BUSY drops, latched data is discarded.
- Outputs are registered (no combinational path from WE/DATA_IN to outputs).
- Counter widths: divider $clog2(WAIT_DIV), bit index 3 bits.

Optional Feature:
- Macro: SERIAL_SEND_PARITY_EN
- Defined: an even-parity bit (XOR of the 8 data bits) is sent between DATA and STOP, held WAIT_DIV cycles. The frame becomes 8E1, and BUSY stays high for 11*WAIT_DIV cycles.
- Undefined: no parity state exists; 8N1 as above.

Decomposition:
- Package uart_serial_send_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP)
  - DATA_BITS=8
  - START_LEVEL=0, STOP_LEVEL=1, IDLE_LEVEL=1
- One sub-module is natural: uart_baud_tick, a WAIT_DIV divider with sync clear and a one-cycle tick output.
- The FSM and shift register stay in the top module.

Test Plan:
- Reset: RST=1 for 30 ns, clock at 50 MHz (20 ns period) -> DATA_OUT=1, BUSY=0 during and after reset.
- Single byte (WAIT_DIV=5, DATA_IN=8'h41, one-cycle WE):
  - DATA_OUT, in 5-cycle slots from the cycle after WE: 0 | 1,0,0,0,0,0,1,0 | 1.
  - BUSY high for exactly 50 cycles, then 0; the bench waits for BUSY low and finishes.
- WE held high / re-pulsed mid-frame with DATA_IN=8'hFF -> frame still carries 8'h41, length unchanged at 50 cycles.
- Back-to-back (WAIT_DIV=5): 8'h55 then 8'hAA, second WE on the first BUSY=0 edge -> two correct frames separated by 1 idle-high cycle.
- Reset asserted at the 20th cycle of a frame -> DATA_OUT=1 and BUSY=0 asynchronously. The next write sends a complete fresh frame.
- Parity (SERIAL_SEND_PARITY_EN, WAIT_DIV=5, 8'h41) -> parity slot = 0 (two ones), BUSY high 55 cycles. 8'h01 -> parity slot = 1.

Source files
------------

// File: rtl/uart_serial_send_pkg.sv
// -----------------------------------------------------------------------------
// uart_serial_send_pkg
//
// Purpose : Shared types and constants for the uart_serial_send transmitter.
//           Holds the FSM state encoding, the data width, and the line levels
//           used for the start, stop and idle conditions.
//
// Optional feature macro: SERIAL_SEND_PARITY_EN
//   When defined, the state enum gains a PARITY state and an even-parity
//   helper becomes available. When undefined, no parity state exists.
// -----------------------------------------------------------------------------
package uart_serial_send_pkg;

    // Payload width of one frame.
    localparam int DATA_BITS = 8;

    // Serial line levels.
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;
    localparam logic IDLE_LEVEL  = 1'b1;

    // Transmitter FSM states. Encodings are fixed so that the parity state
    // can be removed without renumbering the others.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef SERIAL_SEND_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

`ifdef SERIAL_SEND_PARITY_EN
    // Even parity: the extra bit makes the total count of ones even.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction
`endif

endpackage

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
//
// Purpose : Bit-period divider. Counts 0..WAIT_DIV-1 while enabled and emits a
//           one-cycle tick on the terminal count, then wraps to 0. A
//           synchronous clear restarts the count at 0 so a new frame always
//           begins with a full-length start bit.
//
// Parameters:
//   WAIT_DIV  clock cycles per serial bit (>= 2)
//
// Ports:
//   i_clk    system clock (rising edge)
//   i_rst    asynchronous active-high reset, counter -> 0
//   i_clr    synchronous clear, counter -> 0 (wins over i_en)
//   i_en     count enable
//   o_tick   high for one cycle when the counter sits at WAIT_DIV-1 and is
//            enabled (combinational decode of the counter register)
// -----------------------------------------------------------------------------
module uart_baud_tick #(
    parameter int WAIT_DIV = 868
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tick
);

    localparam int CW = (WAIT_DIV > 1) ? $clog2(WAIT_DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(WAIT_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          w_term;

    assign w_term = (r_cnt == TERM);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_term ? '0 : r_cnt + CW'(1);
        end
    end

    // A clear on the same edge takes priority, so no tick is reported then.
    assign o_tick = i_en & w_term & ~i_clr;

endmodule

// File: rtl/uart_serial_send.sv
// -----------------------------------------------------------------------------
// uart_serial_send
//
// Purpose : Minimal UART transmitter. Each accepted write serialises one byte
//           as an 8N1 frame (start low, 8 data bits LSB first, stop high).
//           All outputs are registered; a write accepted on edge N is visible
//           as BUSY=1 / DATA_OUT=0 from the cycle after edge N.
//
// Optional feature macro: SERIAL_SEND_PARITY_EN
//   When defined, an even-parity bit is sent between the last data bit and
//   the stop bit (8E1), and BUSY stays high for 11*WAIT_DIV cycles instead of
//   10*WAIT_DIV.
//
// Parameters:
//   WAIT_DIV  clock cycles per serial bit (>= 2), default 868
//
// Ports:
//   CLK       system clock, rising edge
//   RST       asynchronous active-high reset; aborts any frame in progress
//   DATA_IN   byte to send, sampled only on an accepted write
//   WE        write strobe; accepted when high on an edge with BUSY low
//   DATA_OUT  serial TX line, idles high
//   BUSY      high while a frame is in progress
// -----------------------------------------------------------------------------
module uart_serial_send
    import uart_serial_send_pkg::*;
#(
    parameter int WAIT_DIV = 868
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [DATA_BITS-1:0] DATA_IN,
    input  logic                 WE,
    output logic                 DATA_OUT,
    output logic                 BUSY
);

    // Reject an unusable divider at elaboration time.
    generate
        if (WAIT_DIV < 2) begin : g_bad_div
            $error("uart_serial_send: WAIT_DIV must be >= 2");
        end
    endgenerate

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    state_t               r_state,    w_state_next;
    logic [DATA_BITS-1:0] r_shift,    w_shift_next;
    logic [2:0]           r_bit_idx,  w_bit_idx_next;
    logic                 r_data_out, w_data_out_next;
    logic                 r_busy,     w_busy_next;
`ifdef SERIAL_SEND_PARITY_EN
    logic                 r_parity,   w_parity_next;
`endif

    logic w_accept;
    logic w_tick;

    // Only IDLE accepts; WE at any other time is dropped, not queued.
    assign w_accept = WE & (r_state == IDLE);

    uart_baud_tick #(
        .WAIT_DIV (WAIT_DIV)
    ) u_baud_tick (
        .i_clk  (CLK),
        .i_rst  (RST),
        .i_clr  (w_accept),
        .i_en   (r_busy),
        .o_tick (w_tick)
    );

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_data_out <= IDLE_LEVEL;
            r_busy     <= 1'b0;
`ifdef SERIAL_SEND_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_next;
            r_shift    <= w_shift_next;
            r_bit_idx  <= w_bit_idx_next;
            r_data_out <= w_data_out_next;
            r_busy     <= w_busy_next;
`ifdef SERIAL_SEND_PARITY_EN
            r_parity   <= w_parity_next;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and next-output logic. The line level for the upcoming bit is
    // computed here and registered, so DATA_OUT changes exactly on the tick
    // edge that starts each bit slot.
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next    = r_state;
        w_shift_next    = r_shift;
        w_bit_idx_next  = r_bit_idx;
        w_data_out_next = r_data_out;
        w_busy_next     = r_busy;
`ifdef SERIAL_SEND_PARITY_EN
        w_parity_next   = r_parity;
`endif

        case (r_state)
            IDLE: begin
                w_data_out_next = IDLE_LEVEL;
                w_busy_next     = 1'b0;
                if (w_accept) begin
                    w_state_next    = START;
                    w_shift_next    = DATA_IN;
                    w_bit_idx_next  = '0;
                    w_data_out_next = START_LEVEL;
                    w_busy_next     = 1'b1;
`ifdef SERIAL_SEND_PARITY_EN
                    w_parity_next   = even_parity(DATA_IN);
`endif
                end
            end

            START: begin
                if (w_tick) begin
                    w_state_next    = DATA;
                    w_data_out_next = r_shift[0];
                end
            end

            DATA: begin
                if (w_tick) begin
                    if (r_bit_idx == LAST_BIT) begin
`ifdef SERIAL_SEND_PARITY_EN
                        w_state_next    = PARITY;
                        w_data_out_next = r_parity;
`else
                        w_state_next    = STOP;
                        w_data_out_next = STOP_LEVEL;
`endif
                    end else begin
                        // Shift right so bit 0 is always the bit on the wire;
                        // bit 1 is the one that goes out next.
                        w_bit_idx_next  = r_bit_idx + 3'd1;
                        w_shift_next    = r_shift >> 1;
                        w_data_out_next = r_shift[1];
                    end
                end
            end

`ifdef SERIAL_SEND_PARITY_EN
            PARITY: begin
                if (w_tick) begin
                    w_state_next    = STOP;
                    w_data_out_next = STOP_LEVEL;
                end
            end
`endif

            STOP: begin
                if (w_tick) begin
                    w_state_next    = IDLE;
                    w_data_out_next = IDLE_LEVEL;
                    w_busy_next     = 1'b0;
                end
            end

            default: begin
                w_state_next    = IDLE;
                w_data_out_next = IDLE_LEVEL;
                w_busy_next     = 1'b0;
            end
        endcase
    end

    assign DATA_OUT = r_data_out;
    assign BUSY     = r_busy;

endmodule

// File: tb/tb_uart_serial_send.sv
module tb_uart_serial_send;

    localparam int W = 5;
`ifdef SERIAL_SEND_PARITY_EN
    localparam int NSLOT = 11;
`else
    localparam int NSLOT = 10;
`endif

    typedef struct {
        logic [7:0] data;
        int         gap;   // required idle cycles before this frame, 0 = any
    } exp_t;

    logic       CLK;
    logic       RST;
    logic [7:0] DATA_IN;
    logic       WE;
    logic       DATA_OUT;
    logic       BUSY;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   last_end = 0;
    logic abort_pending = 1'b0;
    exp_t sb_q[$];
    logic lvl [0:255];

    uart_serial_send #(.WAIT_DIV(W)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .DATA_IN  (DATA_IN),
        .WE       (WE),
        .DATA_OUT (DATA_OUT),
        .BUSY     (BUSY)
    );

    initial begin
        CLK = 1'b1;
        forever #10 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference line level for a given slot of a frame carrying byte b.
    function automatic logic exp_level(input logic [7:0] b, input int slot);
        if (slot == 0) return 1'b0;
        if (slot <= 8) return b[slot-1];
`ifdef SERIAL_SEND_PARITY_EN
        if (slot == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic send(input logic [7:0] b, input int gap);
        exp_t e;
        e.data = b;
        e.gap  = gap;
        sb_q.push_back(e);
        DATA_IN = b;
        WE = 1'b1;
        @(posedge CLK);
        #1;
        WE = 1'b0;
        @(negedge CLK);
        check("accept_busy", BUSY, 1);
        check("accept_start", DATA_OUT, 0);
        $display("send 0x%02h", b);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge CLK);
        while (BUSY === 1'b1 && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        if (BUSY !== 1'b0) check("idle_timeout", BUSY, 0);
    endtask

    // Monitor: captures each BUSY-high window and scores it against the queue.
    initial begin : monitor
        int   n;
        int   start_cyc;
        int   idx;
        exp_t e;
        forever begin
            @(negedge CLK);
            if (BUSY === 1'b1) begin
                start_cyc = cyc;
                n = 0;
                while (BUSY === 1'b1 && n < 256) begin
                    lvl[n] = DATA_OUT;
                    n++;
                    @(negedge CLK);
                end
                if (abort_pending) begin
                    abort_pending = 1'b0;
                    if (sb_q.size() > 0) void'(sb_q.pop_front());
                    $display("frame aborted after %0d cycles", n);
                end else if (sb_q.size() == 0) begin
                    check("sb_unexpected_frame", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("frame_len", n, NSLOT * W);
                    if (e.gap != 0) check("frame_gap", start_cyc - last_end, e.gap);
                    for (int s = 0; s < NSLOT; s++) begin
                        for (int c = 0; c < W; c++) begin
                            idx = s * W + c;
                            if (idx < n)
                                check($sformatf("d%02h_slot%0d_c%0d", e.data, s, c),
                                      lvl[idx], exp_level(e.data, s));
                        end
                    end
                    check("idle_high_after", DATA_OUT, 1);
                    $display("frame 0x%02h len=%0d checked", e.data, n);
                end
                last_end = cyc;
            end
        end
    end

    initial begin : stim
        RST = 1'b0;
        WE = 1'b0;
        DATA_IN = 8'h00;
        #1 RST = 1'b1;
        #5;
        check("rst_dout", DATA_OUT, 1);
        check("rst_busy", BUSY, 0);
        #24 RST = 1'b0;          // released at t=30, a falling clock edge
        repeat (2) @(negedge CLK);
        check("post_rst_dout", DATA_OUT, 1);
        check("post_rst_busy", BUSY, 0);

        // Single byte, one-cycle strobe.
        send(8'h41, 0);
        wait_idle();

        // WE held high with DATA_IN changing, then re-pulsed mid-frame.
        begin
            exp_t e;
            e.data = 8'h41;
            e.gap  = 0;
            sb_q.push_back(e);
        end
        DATA_IN = 8'h41;
        WE = 1'b1;
        @(posedge CLK);
        #1 DATA_IN = 8'hFF;
        repeat (20) @(posedge CLK);
        #1 WE = 1'b0;
        repeat (5) @(posedge CLK);
        #1 WE = 1'b1;
        @(posedge CLK);
        #1 WE = 1'b0;
        $display("send 0x41 with WE held/repulsed");
        wait_idle();

        // Back-to-back: second write on the first BUSY-low edge.
        send(8'h55, 0);
        wait_idle();
        send(8'hAA, 1);
        wait_idle();

        // Reset in the 20th cycle of a frame.
        send(8'hC3, 0);
        repeat (18) @(negedge CLK);
        #3;
        abort_pending = 1'b1;
        RST = 1'b1;
        #1;
        check("abort_dout", DATA_OUT, 1);
        check("abort_busy", BUSY, 0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        $display("reset mid-frame");
        @(negedge CLK);
        send(8'h3C, 0);
        wait_idle();

        // Parity-relevant patterns (plain data frames in the default build).
        send(8'h01, 0);
        wait_idle();
        send(8'hFF, 0);
        wait_idle();

        repeat (5) @(negedge CLK);
        check("sb_drain", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
